uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver. The transmit side of the same serial link feeds it; it runs on the 12 MHz board clock.
- Synchronizes the asynchronous rx pin, detects the start bit, and samples each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin and the command/byte consumer logic.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division, 104), clocks per bit period. Derived; localparam.
- HALF_BIT, CLKS_PER_BIT/2 (52), offset from start-bit edge to mid-bit. Derived; localparam.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idle high.
- rx_byte  out  8  last good byte, LSB received first; holds until next good frame.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- rx_frame_err  out  1  one-cycle pulse when the stop bit samples low.
- rx_busy  out  1  high in any state except S_IDLE.

Behaviour:
- Synchronizer: 2 flops, both reset to 1. The FSM sees only the synchronized value, rx_s.
- Counter: 7 bits, wide enough for CLKS_PER_BIT-1. Bit index: 3 bits. Shift register: 8 bits.
- Reset values: rx_byte=0x00, rx_valid=0, rx_frame_err=0, rx_busy=1. State after reset is S_WAIT, counter=0.
- Reset mid-frame: the frame is abandoned and no strobe is issued.
- S_WAIT: arm only once rx_s==1; then go to S_IDLE. This prevents locking onto mid-frame or break data after reset or an error.
- S_IDLE:
  - rx_s==0 -> S_START, counter=0.
  - Otherwise stay; counter held at 0.
- S_START: counter increments each cycle. When counter==HALF_BIT-1, sample rx_s:
  - 0 -> S_DATA, counter=0, bit_idx=0.
  - 1 -> S_IDLE (glitch reject, no strobe).
- S_DATA: when counter==CLKS_PER_BIT-1:
  - Sample the bit: shift right, sample enters bit 7.
  - counter=0, bit_idx+1.
  - After the 8th sample (bit_idx==7) -> S_STOP.
- S_STOP: when counter==CLKS_PER_BIT-1, sample:
  - 1: rx_byte<=shift register, rx_valid=1 for exactly one cycle, go to S_IDLE.
  - 0: rx_frame_err=1 for one cycle, rx_byte unchanged, go to S_WAIT.
- rx_valid and rx_frame_err are registered, mutually exclusive, and never high for two consecutive cycles.
- Latency:
  - rx_valid rises 3+HALF_BIT+9*CLKS_PER_BIT clocks (991 at defaults) after the first clk edge that sees rx low.
  - Bench tolerance is ±2.
- Back-to-back frames:
  - The next start bit may begin immediately after the stop-bit mid-sample.
  - S_IDLE is re-entered roughly half a bit before the stop bit ends.
  - No frame is lost at full line rate.
- rx held low indefinitely (break): one frame_err pulse, then S_WAIT until the line goes high. No further strobes.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - A 3-entry history of rx_s is kept.
  - Every sample point (start check, data bits, stop bit) uses the 2-of-3 majority of the last three rx_s values, ending at the sample cycle.
  - This rejects single-cycle glitches. Latency is unchanged.
- Undefined: a single rx_s sample is used at each sample point; the history register is absent.

Decomposition:
- Package uart_pkg holds:
  - Defaults CLK_HZ=12000000 and BAUD=115200, shared with the transmitter.
  - State encodings S_WAIT, S_IDLE, S_START, S_DATA, S_STOP (3-bit).
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
- Sub-module uart_sync: parameterized N-flop synchronizer with reset value 1, reusable for other async inputs.

Test Plan:
- Idle line, rst pulsed -> rx_byte=0x00, rx_valid never asserts, rx_busy drops to 0 within 3 cycles of rst release.
- Drive 0xA5 at 115200 baud (104 clk/bit, 8N1) -> exactly one rx_valid pulse, rx_byte=0xA5, latency 991±2 cycles, rx_frame_err=0.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three rx_valid pulses in order with correct bytes; no frame_err.
- Frame 0x3C with stop bit driven low, then line high -> one rx_frame_err pulse, rx_byte keeps its prior value, no rx_valid. A following 0x81 is received correctly.
- rx low pulse of 20 clocks, then high -> returns to idle, no strobes. With UART_RX_MAJORITY_EN, a 1-clock glitch inside a 0x5A data bit still yields 0x5A.
- Assert rst midway through a 0xC3 frame, release while rx still mid-frame -> no strobe for that frame (S_WAIT holds until line high). The next clean 0x7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: default clock and line rate, frame
//               shape, receiver state encodings and a 2-of-3 majority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Board defaults, shared with the transmitter
  localparam int unsigned DEF_CLK_HZ = 12000000;
  localparam int unsigned DEF_BAUD   = 115200;

  // Frame shape: 8N1
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;

  // Receiver states
  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } rx_state_e;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync
// Description : N-flop synchronizer for an asynchronous single-bit input.
//               All stages reset to 1 so an idle-high line reads idle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  generate
    if (N == 1) begin : g_single
      // Single stage: just capture the input
      always_comb sync_d = d;
    end else begin : g_chain
      // Shift the async input through the chain, newest in bit 0
      always_comb sync_d = {sync_q[N-2:0], d};
    end
  endgenerate

  // Synchronizer stages, reset to the idle level
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Synchronizes rx, finds the start bit,
//               samples every bit at mid-bit, strobes good bytes and flags
//               stop-bit framing errors.
//               Optional macro UART_RX_MAJORITY_EN: each sample point uses a
//               2-of-3 majority over the last three synchronized values.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ,
  parameter int unsigned BAUD   = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic sample;

  rx_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q,   cnt_d;
  logic [IDX_W-1:0]         idx_q,   idx_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic [DATA_BITS-1:0]     byte_q,  byte_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q,  ferr_d;
  logic                     busy_q,  busy_d;

  uart_sync #(
    .N (2)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two previous rx_s values; together with the current one they form the
  // three-entry window voted on at every sample point
  logic [1:0] hist_q, hist_d;

  // Shift the synchronized line into the history
  always_comb hist_d = {hist_q[0], rx_s};

  // History register, reset to idle level
  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end

  // Majority of the window ending at the current cycle
  always_comb sample = maj3(hist_q[1], hist_q[0], rx_s);
`else
  // Plain single-sample decision
  always_comb sample = rx_s;
`endif

  // Next-state, datapath and strobe computation for the receive FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_WAIT: begin
        // Only arm once the line is seen idle, never mid-frame or in break
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end

      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d = '0;
          if (!sample) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            // Start bit did not hold to mid-bit: treat as a glitch
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d   = '0;
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = '0;
          if (sample) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Register state, datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_byte      = byte_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Frames are driven bit by
//               bit; expected bytes and start times go to a scoreboard queue
//               and are popped when rx_valid strobes.
//               Optional macro UART_RX_MAJORITY_EN enables the glitch case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BIT_CLKS = 104;
  localparam int LAT_NOM  = 991;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_ferr = 0;
  int   obs_ferr = 0;
  exp_t sb_q[$];

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: match every strobe against the oldest expected frame
  always @(negedge clk) begin
    if (rx_valid) begin
      check("valid_ferr_excl", {31'd0, rx_frame_err}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int   lat;
        e   = sb_q.pop_front();
        lat = cyc - e.start;
        check("rx_byte", {24'd0, rx_byte}, {24'd0, e.data});
        check("latency", (lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2) ? LAT_NOM : lat, LAT_NOM);
      end
    end
    if (rx_frame_err) obs_ferr++;
  end

  // Drive one bit period at negedges, optionally inverting one clock of it
  task automatic send_bit(input logic b, input int glitch_at);
    for (int c = 0; c < BIT_CLKS; c++) begin
      rx = (c == glitch_at) ? ~b : b;
      @(negedge clk);
    end
  endtask

  // Drive a full 8N1 frame; good frames are pushed to the scoreboard
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic expect_byte, input int glitch_bit);
    exp_t e;
    e.data  = data;
    e.start = cyc + 1;
    if (expect_byte) sb_q.push_back(e);
    if (!stop_bit) exp_ferr++;
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(data[i], (i == glitch_bit) ? 51 : -1);
    send_bit(stop_bit, -1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    check({tag, "_ferr_count"}, obs_ferr, exp_ferr);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_byte",  {24'd0, rx_byte}, 32'h00);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr",  {31'd0, rx_frame_err}, 32'd0);
    check("rst_busy",  {31'd0, rx_busy}, 32'd1);
    rst = 1'b0;
    n = 0;
    while (rx_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("busy_drop_within_3", {31'd0, (n <= 3)}, 32'd1);
    idle(200);
    check_drained("idle");

    // Single frame
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    idle(200);
    check_drained("a5");
    check("a5_hold", {24'd0, rx_byte}, 32'hA5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    send_frame(8'h55, 1'b1, 1'b1, -1);
    idle(200);
    check_drained("b2b");

    // Framing error keeps previous byte, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(300);
    check_drained("ferr");
    check("ferr_byte_kept", {24'd0, rx_byte}, 32'h55);
    send_frame(8'h81, 1'b1, 1'b1, -1);
    idle(200);
    check_drained("after_ferr");

    // Short low pulse is rejected as a glitch
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(300);
    check_drained("glitch20");
    check("glitch20_idle", {31'd0, rx_busy}, 32'd0);
    check("glitch20_byte", {24'd0, rx_byte}, 32'h81);

`ifdef UART_RX_MAJORITY_EN
    // One-clock inversion at the mid-bit of data bit 3 is voted out
    send_frame(8'h5A, 1'b1, 1'b1, 3);
    idle(200);
    check_drained("maj_glitch");
`endif

    // Break: one framing error, then no further strobes while low
    exp_ferr++;
    rx = 1'b0;
    repeat (3000) @(negedge clk);
    check("break_busy", {31'd0, rx_busy}, 32'd1);
    idle(300);
    check_drained("break");
    check("break_idle", {31'd0, rx_busy}, 32'd0);

    // Reset asserted in data bit 4, released in data bit 6 (line high)
    fork
      send_frame(8'hC3, 1'b1, 1'b0, -1);
      begin
        repeat (BIT_CLKS * 5 + 50) @(negedge clk);
        rst = 1'b1;
        repeat (BIT_CLKS * 2) @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(300);
    check_drained("midrst");
    check("midrst_byte", {24'd0, rx_byte}, 32'h00);
    send_frame(8'h7E, 1'b1, 1'b1, -1);
    idle(200);
    check_drained("after_midrst");
    check("final_byte", {24'd0, rx_byte}, 32'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule : tb_uart_rx
`default_nettype wire
